// File: rtl/qmac_accum.sv
// Streaming sign-magnitude fixed-point dot-product engine: operand register,
// qmult product register, wide two's-complement accumulator, then a saturating
// sign-magnitude conversion of the sum.

module qmult #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] p_o
);

  logic [2*N-3:0] full_s;
  logic [N-2:0]   mag_s;
  logic           unused_s;

  assign full_s   = {{(N-1){1'b0}}, a_i[N-2:0]} * {{(N-1){1'b0}}, b_i[N-2:0]};
  assign mag_s    = full_s[N-2+Q:Q];
  // Bits outside the Q window are dropped on purpose (truncation and silent overflow).
  assign unused_s = ^{full_s[2*N-3:N-1+Q], full_s[Q-1:0]};
  assign p_o      = (mag_s == '0) ? '0 : {a_i[N-1] ^ b_i[N-1], mag_s};

endmodule

module qmac_accum #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [N-1:0]     i_a,
  input  logic [N-1:0]     i_b,
  output logic [N-1:0]     o_result,
  output logic             o_done,
  output logic             o_ovr
);

  localparam int AW = N + LEN_W;
  localparam logic [AW-1:0]    MAX_MAG = {{(LEN_W+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_DRAIN1 = 3'd2,
    S_DRAIN2 = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     op_a_q, op_b_q;
  logic             op_vld_q;
  logic [N-1:0]     prod_s, prod_q;
  logic             prod_vld_q;
  logic [AW-1:0]    acc_q, acc_d;
  logic [AW-1:0]    prod_ext_s, acc_mag_s;
  logic             acc_neg_s;
  logic [N-1:0]     result_q, result_d;
  logic             ovr_q, ovr_d;
  logic             xfer_s, start_s, done_entry_s;

  qmult #(.Q(Q), .N(N)) u_qmult (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (prod_s)
  );

  assign xfer_s       = (state_q == S_RUN) && i_valid;
  assign done_entry_s = (state_d == S_DONE) && (state_q != S_DONE);
  assign o_ready      = (state_q == S_RUN);
  assign o_done       = (state_q == S_DONE);
  assign o_result     = result_q;
  assign o_ovr        = ovr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          start_s = 1'b1;
          cnt_d   = i_len;
          state_d = (i_len == '0) ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (xfer_s) begin
          cnt_d   = cnt_q - LEN_ONE;
          state_d = (cnt_q == LEN_ONE) ? S_DRAIN1 : S_RUN;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN1: state_d = S_DRAIN2;
      S_DRAIN2: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Accumulate next value; a new job starts from zero.
  always_comb begin
    prod_ext_s = {{(LEN_W+1){1'b0}}, prod_q[N-2:0]};
    if (start_s) begin
      acc_d = '0;
    end else if (prod_vld_q) begin
      acc_d = prod_q[N-1] ? (acc_q - prod_ext_s) : (acc_q + prod_ext_s);
    end else begin
      acc_d = acc_q;
    end
    acc_neg_s = acc_d[AW-1];
    acc_mag_s = acc_neg_s ? (~acc_d + {{(AW-1){1'b0}}, 1'b1}) : acc_d;
  end

  always_comb begin
    result_d = result_q;
    ovr_d    = ovr_q;
    if (done_entry_s) begin
      if (acc_mag_s > MAX_MAG) begin
        result_d = {acc_neg_s, MAX_MAG[N-2:0]};
        ovr_d    = 1'b1;
      end else begin
        result_d = {acc_neg_s, acc_mag_s[N-2:0]};
        ovr_d    = 1'b0;
      end
    end else if (start_s) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_vld_q   <= 1'b0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      result_q   <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_vld_q   <= xfer_s;
      if (xfer_s) begin
        op_a_q <= i_a;
        op_b_q <= i_b;
      end
      prod_q     <= prod_s;
      prod_vld_q <= op_vld_q;
      acc_q      <= acc_d;
      result_q   <= result_d;
      ovr_q      <= ovr_d;
    end
  end

endmodule

// File: tb/tb_qmac_accum.sv
// Directed and randomized bench for qmac_accum; expected sums come from an
// integer model of the sign-magnitude product and saturation rules.

module tb_qmac_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_len = 8'd0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_a = 32'd0;
  logic [31:0] i_b = 32'd0;
  logic [31:0] o_result;
  logic        o_done;
  logic        o_ovr;

  int n_cmp = 0;
  int n_fail = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          qg[$];

  qmac_accum #(.Q(15), .N(32), .LEN_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_len    (i_len),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_result (o_result),
    .o_done   (o_done),
    .o_ovr    (o_ovr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Real-valued product in units of 2^-15, truncated and wrapped to 31 magnitude bits.
  function automatic longint prod_val(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, m;
    ma = {33'd0, a[30:0]};
    mb = {33'd0, b[30:0]};
    m  = ((ma * mb) >> 15) & 64'h0000_0000_7FFF_FFFF;
    if (a[31] ^ b[31]) return -longint'(m);
    else return longint'(m);
  endfunction

  task automatic model(output logic [31:0] res, output logic ovr);
    longint sum, t;
    sum = 64'sd0;
    foreach (qa[i]) sum += prod_val(qa[i], qb[i]);
    if (sum > 64'sd2147483647) begin
      res = 32'h7FFF_FFFF; ovr = 1'b1;
    end else if (sum < -64'sd2147483647) begin
      res = 32'hFFFF_FFFF; ovr = 1'b1;
    end else if (sum < 64'sd0) begin
      t = -sum; res = {1'b1, t[30:0]}; ovr = 1'b0;
    end else begin
      t = sum; res = {1'b0, t[30:0]}; ovr = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one job from the queues; qg gives per-pair i_valid gaps (0 if absent).
  task automatic run_job(input string tag, input bit inject_start);
    logic [31:0] exp_res;
    logic        exp_ovr;
    int          len, g, k;
    len = qa.size();
    model(exp_res, exp_ovr);
    i_start = 1'b1;
    i_len   = 8'(len);
    tick();
    i_start = 1'b0;
    if (len == 0) begin
      check({tag, "_done_len0"}, {31'd0, o_done}, 32'd1);
    end else begin
      for (int i = 0; i < len; i++) begin
        g = (i < qg.size()) ? qg[i] : 0;
        for (int j = 0; j < g; j++) begin
          i_valid = 1'b0;
          i_a     = $urandom;
          i_b     = $urandom;
          if (inject_start) begin
            i_start = 1'b1;
            i_len   = 8'd0;
          end
          tick();
          i_start = 1'b0;
        end
        i_valid = 1'b1;
        i_a     = qa[i];
        i_b     = qb[i];
        check({tag, "_ready_run"}, {31'd0, o_ready}, 32'd1);
        tick();
      end
      i_valid = 1'b0;
      check({tag, "_ready_drop"}, {31'd0, o_ready}, 32'd0);
      k = 0;
      while (!o_done && k < 20) begin
        tick();
        k++;
      end
      check({tag, "_latency"}, 32'(k), 32'd2);
    end
    check({tag, "_result"}, o_result, exp_res);
    check({tag, "_ovr"}, {31'd0, o_ovr}, {31'd0, exp_ovr});
    tick();
    check({tag, "_done_pulse"}, {31'd0, o_done}, 32'd0);
    check({tag, "_hold"}, o_result, exp_res);
  endtask

  task automatic load2(input logic [31:0] a0, b0, a1, b1);
    qa = {a0, a1};
    qb = {b0, b1};
    qg = {};
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] tmp;
    int          len, mode;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", {31'd0, o_ready}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_ovr", {31'd0, o_ovr}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1;
      i_a     = 32'h0000_8000;
      i_b     = 32'h0000_8000;
      tick();
      check("idle_ready", {31'd0, o_ready}, 32'd0);
    end
    i_valid = 1'b0;

    load2(32'h0000_4000, 32'h0000_4000, 32'h8000_4000, 32'h0000_2000);
    run_job("basic", 1'b0);
    check("basic_const", o_result, 32'h0000_1000);

    load2(32'h4000_0000, 32'h0000_8000, 32'h4000_0000, 32'h0000_8000);
    run_job("sat_pos", 1'b0);
    check("sat_pos_const", o_result, 32'h7FFF_FFFF);

    load2(32'h4000_0000, 32'h0000_8000, 32'hC000_0000, 32'h0000_8000);
    run_job("sat_cancel", 1'b0);

    load2(32'hC000_0000, 32'h0000_8000, 32'hC000_0000, 32'h0000_8000);
    run_job("sat_neg", 1'b0);

    qa = {32'h8000_0000}; qb = {32'h0000_8000}; qg = {};
    run_job("negzero", 1'b0);

    qa = {}; qb = {}; qg = {};
    run_job("len0", 1'b0);

    qa = {32'h0001_2345, 32'h8000_7000, 32'h0003_0000};
    qb = {32'h0000_9000, 32'h0002_1000, 32'h8000_0800};
    qg = {};
    run_job("nogap3", 1'b0);
    tmp = o_result;
    qg = {0, 2, 5};
    run_job("gap3", 1'b1);
    check("gap3_vs_nogap", o_result, tmp);

    qa = {32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000};
    qb = {32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000};
    i_start = 1'b1;
    i_len   = 8'd4;
    tick();
    i_start = 1'b0;
    i_valid = 1'b1;
    i_a     = 32'h0010_0000;
    i_b     = 32'h0010_0000;
    tick();
    i_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", {31'd0, o_ready}, 32'd0);
    check("abort_result", o_result, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_done", {31'd0, o_done}, 32'd0);
      tick();
    end
    qa = {32'h0000_8000}; qb = {32'h0000_8000}; qg = {};
    run_job("after_abort", 1'b0);
    check("after_abort_const", o_result, 32'h0000_8000);

    for (int n = 0; n < 25; n++) begin
      len  = $urandom_range(1, 6);
      mode = $urandom_range(0, 2);
      qa = {}; qb = {}; qg = {};
      for (int i = 0; i < len; i++) begin
        case (mode)
          0: begin
            qa.push_back({1'($urandom), 31'($urandom_range(0, 32'h000F_FFFF))});
            qb.push_back({1'($urandom), 31'($urandom_range(0, 32'h000F_FFFF))});
          end
          1: begin
            qa.push_back({1'($urandom), 31'($urandom_range(32'h2000_0000, 32'h7FFF_FFFF))});
            qb.push_back({1'($urandom), 31'($urandom_range(32'h0000_4000, 32'h0001_0000))});
          end
          default: begin
            qa.push_back($urandom);
            qb.push_back($urandom);
          end
        endcase
        qg.push_back($urandom_range(0, 2));
      end
      run_job("rand", 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/qmac_accum.md
Name: qmac_accum

Overview:
Sequential fixed-point multiply-accumulate (dot-product) engine for the Codec2 encoder datapath. It consumes a stream of operand pairs in sign-magnitude Q(N,Q) format, forms each product with an internal qmult instance, and accumulates the products. It returns one saturated sign-magnitude sum per job. Typical upstream users are the LPC autocorrelation and energy stages, which use it as a streaming dot-product.

Parameters:
Q, 15, fractional bits of all operands and of the result
N, 32, total word width; bit N-1 is sign, bits N-2:0 are magnitude
LEN_W, 8, width of the job-length field (maximum 2^LEN_W-1 pairs)

Ports:
clk  input  1  system clock, all state on the rising edge
rst  input  1  synchronous, active-high reset
i_start  input  1  one-cycle job start pulse, sampled only in IDLE
i_len  input  LEN_W  number of pairs in the job, latched on an accepted i_start
i_valid  input  1  operand pair on i_a/i_b is valid
o_ready  output  1  block accepts a pair this cycle
i_a  input  N  multiplicand, sign-magnitude Q(N,Q)
i_b  input  N  multiplier, sign-magnitude Q(N,Q)
o_result  output  N  accumulated sum, sign-magnitude Q(N,Q)
o_done  output  1  one-cycle pulse: o_result is valid for the job just finished
o_ovr  output  1  accumulator saturated during the last job; held with o_result

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state=IDLE.
  - o_ready=0, o_done=0, o_result=0, o_ovr=0.
  - Remaining-count, product register and accumulator cleared; any job in flight is abandoned.
- States and transitions:
  - IDLE --i_start--> RUN (i_len latched, accumulator cleared, o_ovr cleared). If i_len=0, go to DONE instead.
  - RUN --last pair accepted--> DRAIN.
  - DRAIN (2 cycles: product stage, then accumulate stage) --> DONE.
  - DONE --> IDLE after 1 cycle. o_done=1 only while in DONE.
- Handshake:
  - o_ready=1 only in RUN.
  - A pair is transferred when i_valid & o_ready. The remaining count decrements on each transfer.
  - i_valid while not RUN is ignored. i_start outside IDLE is ignored.
- Datapath pipeline:
  - Stage 1: the qmult result of the accepted pair is registered, with a product-valid bit.
  - Stage 2: the registered product is converted to two's complement and added into an (N+LEN_W)-bit signed accumulator.
  - Product rule (qmult rule):
    - sign = a[N-1]^b[N-1].
    - magnitude = (a[N-2:0]*b[N-2:0])[N-2+Q:Q], truncated.
    - Magnitude bits above the result range are discarded silently and do not set o_ovr.
  - A product with magnitude 0 is treated as +0 regardless of its sign bit.
- Latency:
  - Last pair accepted at edge E. Product registered at E+1, accumulated at E+2, o_done high in the cycle after E+2.
  - Job length 0: o_done one cycle after the start edge, result 0.
- Output conversion (registered on entry to DONE):
  - Magnitude of the accumulator > 2^(N-1)-1: saturate the magnitude to 2^(N-1)-1, keep the true sign, o_ovr=1.
  - Zero sum: o_result=0 with sign bit 0, never negative zero.
- o_result and o_ovr hold after DONE until the next accepted i_start clears o_ovr. o_result is overwritten at the next DONE.
- Stalls: i_valid=0 gaps in RUN are allowed for any length; the accumulator is unaffected.
- rst during RUN/DRAIN aborts the job: no o_done, outputs return to reset values.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> o_ready=0, o_done=0, o_result=0x00000000, o_ovr=0. i_valid pulses while IDLE are ignored.
- Basic dot product, len=2, no gaps:
  - Stimulus: (0x00004000,0x00004000), (0x80004000,0x00002000), i.e. 0.25 + (-0.125).
  - Required: o_result=0x00001000, o_ovr=0, o_done 3 cycles after the last transfer edge.
- Saturation, len=2:
  - Stimulus: (0x40000000,0x00008000) twice.
  - Required: o_result=0x7FFFFFFF, o_ovr=1. Same stimulus with the second a negative -> 0x00000000, o_ovr=0.
- Negative zero / zero length:
  - Stimulus: len=1 with (0x80000000,0x00008000) -> o_result=0x00000000.
  - Stimulus: len=0 -> o_done one cycle after start, o_result=0.
- Back-pressure and stalls:
  - len=3 with i_valid gaps of 0, 2 and 5 cycles -> exactly 3 transfers; same result as the gap-free run; o_ready drops the cycle after the third transfer.
  - i_start during RUN is ignored.
- Reset mid-job: assert rst after 1 of 4 pairs -> no o_done. A following len=1 job (0x00008000,0x00008000) gives 0x00008000 with no residue from the aborted job.
